sort_packet_tx: RTL and testbench

Packet-stream transmitter feeding the sorter input side. A host loads up to 2**AWIDTH words into a local buffer, then issues a start with a length. The block emits the words as one contiguous sop/eop/val packet. It does not start a new packet while the downstream sorter reports busy, and it observes a fixed post-packet gap that covers the sorter's registered busy latency.

---
 rtl/sort_packet_tx_pkg.sv | 22 ++
 rtl/sort_packet_tx_ram.sv | 32 +++
 rtl/sort_packet_tx.sv | 159 +++++++++++++++
 tb/tb_sort_packet_tx.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_packet_tx_pkg.sv
// Shared types and helpers for the sorter-side packet transmitter.
// Holds the FSM state enum, default widths and the length clipping function.
package sort_packet_tx_pkg;

  localparam int unsigned AWIDTH_DEF = 3;
  localparam int unsigned DWIDTH_DEF = 8;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StSend,
    StGap
  } state_e;

  // Clips a requested length to the buffer depth 2**awidth (awidth up to 15).
  function automatic logic [15:0] clip_len(input logic [15:0] len, input int unsigned awidth);
    logic [15:0] max_len;
    max_len = 16'(1 << awidth);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/sort_packet_tx_ram.sv
// Simple dual-port packet buffer: one write port, one registered read port.
// No reset; the read register only updates on a read so it holds between packets.
module sort_packet_tx_ram
  import sort_packet_tx_pkg::*;
#(
  parameter int unsigned AWIDTH = AWIDTH_DEF,
  parameter int unsigned DWIDTH = DWIDTH_DEF
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [AWIDTH-1:0] wr_addr_i,
  input  logic [DWIDTH-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [AWIDTH-1:0] rd_addr_i,
  output logic [DWIDTH-1:0] rd_data_o
);

  logic [DWIDTH-1:0] mem_q [2**AWIDTH];
  logic [DWIDTH-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sort_packet_tx.sv
// Packet transmitter: host fills a buffer, then a start emits it as one sop/eop/val packet,
// waiting for the sorter to be idle and enforcing a post-packet gap.
module sort_packet_tx
  import sort_packet_tx_pkg::*;
#(
  parameter int unsigned AWIDTH = AWIDTH_DEF,
  parameter int unsigned DWIDTH = DWIDTH_DEF,
  parameter int unsigned GAP    = 2
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [AWIDTH-1:0] wr_addr_i,
  input  logic [DWIDTH-1:0] wr_data_i,
  input  logic              wr_i,
  input  logic [AWIDTH:0]   len_i,
  input  logic              start_i,
  input  logic              busy_i,
  output logic [DWIDTH-1:0] data_o,
  output logic              sop_o,
  output logic              eop_o,
  output logic              val_o,
  output logic              ready_o
);

  localparam int unsigned LW = AWIDTH + 1;
  localparam logic [AWIDTH:0] LenOne = LW'(1);
  localparam logic [3:0] GapLast = 4'(GAP - 1);

  state_e state_q, state_d;
  logic [AWIDTH:0] len_q, len_d, cnt_q, cnt_d, len_m1;
  logic [3:0] gap_q, gap_d;

  logic              start_ok;
  logic              wr_en;
  logic              rd_en;
  logic              rd_first;
  logic              rd_last;
  logic [AWIDTH-1:0] rd_addr;
  logic [DWIDTH-1:0] rd_data;

  logic val_q, sop_q, eop_q, data_seen_q;

  assign start_ok = start_i && (len_i != '0);
  assign len_m1   = len_q - LenOne;

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      state_q <= StIdle;
      len_q   <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          state_d = StWait;
          len_d   = LW'(clip_len(16'(len_i), AWIDTH));
        end
      end
      StWait: begin
        if (!busy_i) begin
          cnt_d   = LenOne;
          gap_d   = '0;
          state_d = (len_q == LenOne) ? StGap : StSend;
        end
      end
      StSend: begin
        cnt_d = cnt_q + LenOne;
        if (cnt_q == len_m1) begin
          state_d = StGap;
          gap_d   = '0;
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
    endcase
  end

  always_comb begin
    ready_o  = 1'b0;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    rd_first = 1'b0;
    rd_last  = 1'b0;
    rd_addr  = '0;
    unique case (state_q)
      StIdle: begin
        ready_o = 1'b1;
        wr_en   = wr_i;
      end
      StWait: begin
        rd_en    = !busy_i;
        rd_first = !busy_i;
        rd_last  = !busy_i && (len_q == LenOne);
      end
      StSend: begin
        rd_en   = 1'b1;
        rd_addr = cnt_q[AWIDTH-1:0];
        rd_last = (cnt_q == len_m1);
      end
      default: ;
    endcase
  end

  sort_packet_tx_ram #(
    .AWIDTH (AWIDTH),
    .DWIDTH (DWIDTH)
  ) u_ram (
    .clk_i     (clk_i),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  // Flags track the read one cycle behind; the RAM read register is the data stage.
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      val_q       <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      data_seen_q <= 1'b0;
    end else begin
      val_q <= rd_en;
      sop_q <= rd_first;
      eop_q <= rd_last;
      if (rd_en) begin
        data_seen_q <= 1'b1;
      end
    end
  end

  // The unreset RAM read register is masked to zero until the first read after reset.
  assign data_o = data_seen_q ? rd_data : '0;
  assign val_o  = val_q;
  assign sop_o  = sop_q;
  assign eop_o  = eop_q;

endmodule

// File: tb/tb_sort_packet_tx.sv
// Directed, table-driven bench for sort_packet_tx (AWIDTH=3, DWIDTH=8, GAP=2).
module tb_sort_packet_tx;

  localparam int GAPV = 2;

  logic       clk_i = 1'b0;
  logic       srst_i = 1'b1;
  logic [2:0] wr_addr_i = '0;
  logic [7:0] wr_data_i = '0;
  logic       wr_i = 1'b0;
  logic [3:0] len_i = '0;
  logic       start_i = 1'b0;
  logic       busy_i = 1'b0;
  logic [7:0] data_o;
  logic       sop_o, eop_o, val_o, ready_o;

  sort_packet_tx #(
    .AWIDTH (3),
    .DWIDTH (8),
    .GAP    (GAPV)
  ) dut (
    .clk_i     (clk_i),
    .srst_i    (srst_i),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i),
    .wr_i      (wr_i),
    .len_i     (len_i),
    .start_i   (start_i),
    .busy_i    (busy_i),
    .data_o    (data_o),
    .sop_o     (sop_o),
    .eop_o     (eop_o),
    .val_o     (val_o),
    .ready_o   (ready_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [7:0] model [8];

  logic [7:0] cap_data [16];
  bit cap_sop [16];
  bit cap_eop [16];
  int cap_n, cap_first, cap_last, cap_eop_at, cap_eop_abs, cap_sop_abs, cap_ready_back;
  bit cap_ready_low, cap_ready_at_eop;

  typedef struct {
    int         len_in;
    int         busy_hold;
    bit         wr0;
    logic [7:0] wr0_data;
    int         exp_n;
    int         exp_lat;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic wr_word(input int addr, input logic [7:0] d);
    @(negedge clk_i);
    wr_i = 1'b1;
    wr_addr_i = 3'(addr);
    wr_data_i = d;
    model[addr] = d;
    @(negedge clk_i);
    wr_i = 1'b0;
  endtask

  // Call at a negedge; the start is accepted at the following posedge.
  task automatic start_pkt(input int len, input bit busy_pre, input bit w0, input logic [7:0] d0);
    len_i = 4'(len);
    start_i = 1'b1;
    busy_i = busy_pre;
    if (w0) begin
      wr_i = 1'b1;
      wr_addr_i = '0;
      wr_data_i = d0;
      model[0] = d0;
    end
  endtask

  // k counts negedges after the accepting posedge; returns at the negedge where ready comes back.
  task automatic capture(input int busy_hold, input bit disturb);
    cap_n = 0; cap_first = -1; cap_last = -1; cap_eop_at = -1; cap_ready_back = -1;
    cap_eop_abs = -1; cap_sop_abs = -1; cap_ready_low = 1'b0; cap_ready_at_eop = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk_i);
      if (!ready_o) cap_ready_low = 1'b1;
      if (val_o) begin
        if (cap_first < 0) cap_first = k;
        cap_last = k;
        if (cap_n < 16) begin
          cap_data[cap_n] = data_o;
          cap_sop[cap_n] = sop_o;
          cap_eop[cap_n] = eop_o;
        end
        if (sop_o && cap_sop_abs < 0) cap_sop_abs = cyc;
        cap_n++;
        if (eop_o && cap_eop_at < 0) begin
          cap_eop_at = k;
          cap_eop_abs = cyc;
          cap_ready_at_eop = ready_o;
        end
      end
      if (k == 1) begin
        start_i = 1'b0;
        wr_i = 1'b0;
      end
      if (k == busy_hold) busy_i = 1'b0;
      if (disturb && k >= 2 && k <= 5) begin
        busy_i = 1'b1; wr_i = 1'b1; wr_addr_i = 3'd3; wr_data_i = 8'hEE;
        start_i = 1'b1; len_i = 4'd2;
      end
      if (disturb && k == 6) begin
        busy_i = 1'b0; wr_i = 1'b0; start_i = 1'b0;
      end
      if (cap_eop_at > 0 && ready_o) begin
        cap_ready_back = k - cap_eop_at;
        break;
      end
    end
    start_i = 1'b0; wr_i = 1'b0; busy_i = 1'b0;
  endtask

  task automatic check_pkt(input string tag, input int n);
    check({tag, " words"}, cap_n, n);
    for (int i = 0; i < n && i < 16; i++) begin
      check($sformatf("%s data[%0d]", tag, i), cap_data[i], model[i]);
      check($sformatf("%s sop/eop[%0d]", tag, i), {cap_sop[i], cap_eop[i]},
            {(i == 0), (i == n - 1)});
    end
    if (n > 0) begin
      check({tag, " contiguous"}, cap_last - cap_first + 1, n);
      check({tag, " ready low at eop"}, cap_ready_at_eop, 0);
      check({tag, " ready returns"}, (cap_ready_back > 0), 1);
    end
  endtask

  initial begin
    int n, spacing, bad;
    vecs[0] = '{len_in: 8,  busy_hold: 0,  wr0: 0, wr0_data: 8'h00, exp_n: 8, exp_lat: 2};
    vecs[1] = '{len_in: 1,  busy_hold: 0,  wr0: 1, wr0_data: 8'hAA, exp_n: 1, exp_lat: 2};
    vecs[2] = '{len_in: 12, busy_hold: 0,  wr0: 0, wr0_data: 8'h00, exp_n: 8, exp_lat: 2};
    vecs[3] = '{len_in: 0,  busy_hold: 0,  wr0: 0, wr0_data: 8'h00, exp_n: 0, exp_lat: -1};
    vecs[4] = '{len_in: 5,  busy_hold: 20, wr0: 0, wr0_data: 8'h00, exp_n: 5, exp_lat: 21};
    vecs[5] = '{len_in: 3,  busy_hold: 4,  wr0: 0, wr0_data: 8'h00, exp_n: 3, exp_lat: 5};
    vecs[6] = '{len_in: 15, busy_hold: 0,  wr0: 0, wr0_data: 8'h00, exp_n: 8, exp_lat: 2};

    // Reset state
    @(negedge clk_i);
    check("reset val", val_o, 0);
    check("reset sop/eop", {sop_o, eop_o}, 0);
    check("reset data", data_o, 0);
    check("reset ready", ready_o, 1);
    srst_i = 1'b0;

    wr_word(0, 8'h07); wr_word(1, 8'h03); wr_word(2, 8'h05); wr_word(3, 8'h01);
    wr_word(4, 8'h08); wr_word(5, 8'h02); wr_word(6, 8'h06); wr_word(7, 8'h04);

    for (int v = 0; v < 7; v++) begin
      @(negedge clk_i);
      start_pkt(vecs[v].len_in, (vecs[v].busy_hold > 0), vecs[v].wr0, vecs[v].wr0_data);
      capture(vecs[v].busy_hold, 1'b0);
      check($sformatf("v%0d latency", v), cap_first, vecs[v].exp_lat);
      check_pkt($sformatf("v%0d", v), vecs[v].exp_n);
      if (vecs[v].exp_n == 0) check($sformatf("v%0d ready stays", v), cap_ready_low, 0);
    end

    // Back-to-back packets: eop to next sop spacing
    @(negedge clk_i);
    start_pkt(2, 1'b0, 1'b0, 8'h00);
    capture(0, 1'b0);
    n = cap_eop_abs;
    start_pkt(2, 1'b0, 1'b0, 8'h00);
    capture(0, 1'b0);
    spacing = cap_sop_abs - n;
    check("eop to sop spacing", spacing, GAPV + 2);

    // Busy, writes and starts during SEND are ignored
    @(negedge clk_i);
    start_pkt(8, 1'b0, 1'b0, 8'h00);
    capture(0, 1'b1);
    check_pkt("disturbed", 8);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      if (val_o) bad++;
    end
    check("dropped start no packet", bad, 0);
    start_pkt(8, 1'b0, 1'b0, 8'h00);
    capture(0, 1'b0);
    check_pkt("after disturb", 8);

    // Reset on the 4th word truncates the packet
    @(negedge clk_i);
    start_pkt(8, 1'b0, 1'b0, 8'h00);
    n = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk_i);
      if (k == 1) start_i = 1'b0;
      if (val_o) n++;
      if (n == 4) begin
        check("rst word4 data", data_o, model[3]);
        #1 srst_i = 1'b1;
        #1;
        check("rst outputs", {val_o, sop_o, eop_o}, 0);
        check("rst data", data_o, 0);
        check("rst ready", ready_o, 1);
        break;
      end
    end
    check("rst reached word4", n, 4);
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      if (val_o || eop_o) bad++;
      if (k == 1) srst_i = 1'b0;
    end
    check("no eop after reset", bad, 0);
    srst_i = 1'b0;
    @(negedge clk_i);
    start_pkt(8, 1'b0, 1'b0, 8'h00);
    capture(0, 1'b0);
    check("restart latency", cap_first, 2);
    check_pkt("restart", 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
